// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, imem req/ack handshake, one-entry skid buffer, IF/ID register.
// Optional macro FETCH_BUBBLE_CNT_EN adds fetch_bubble_cnt_o, a saturating count of non-idle bubble cycles.
module if_fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] if_id_pc_o,
    output logic [INST_W-1:0] if_id_inst_o,
    output logic              if_id_valid_o
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [31:0]       fetch_bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } fetchState_t;

    fetchState_t       state,         stateNext;
    logic [ADDR_W-1:0] pc,            pcNext;
    logic [ADDR_W-1:0] ifIdPc,        ifIdPcNext;
    logic [INST_W-1:0] ifIdInst,      ifIdInstNext;
    logic              ifIdValid,     ifIdValidNext;
    logic [INST_W-1:0] skidInst,      skidInstNext;
    logic [ADDR_W-1:0] skidPc,        skidPcNext;
    logic              squash,        squashNext;
    logic [ADDR_W-1:0] latchedTarget, latchedTargetNext;
    logic              imemReq;
    logic [ADDR_W-1:0] pcPlus4;

    assign pcPlus4 = pc + ADDR_W'(4);

    // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext         = state;
        pcNext            = pc;
        ifIdPcNext        = ifIdPc;
        ifIdInstNext      = ifIdInst;
        ifIdValidNext     = ifIdValid;
        skidInstNext      = skidInst;
        skidPcNext        = skidPc;
        squashNext        = squash;
        latchedTargetNext = latchedTarget;
        imemReq           = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_i) stateNext = FETCH;
            end

            FETCH: begin
                imemReq = 1'b1;
                if (imem_ack_i) begin
                    if (squash) begin
                        // Response belongs to a squashed request; a newer flush overrides the saved target.
                        squashNext = 1'b0;
                        pcNext     = flush_i ? branch_target_i : latchedTarget;
                        if (flush_i || !hold_i) begin
                            ifIdInstNext  = '0;
                            ifIdValidNext = 1'b0;
                        end
                    end else if (flush_i) begin
                        pcNext        = branch_target_i;
                        ifIdInstNext  = '0;
                        ifIdValidNext = 1'b0;
                    end else if (hold_i) begin
                        skidInstNext = imem_data_i;
                        skidPcNext   = pcPlus4;
                        pcNext       = pcPlus4;
                        stateNext    = HELD;
                    end else begin
                        ifIdPcNext    = pcPlus4;
                        ifIdInstNext  = imem_data_i;
                        ifIdValidNext = 1'b1;
                        pcNext        = pcPlus4;
                    end
                end else if (flush_i) begin
                    // The in-flight request still completes on the old address; remember where to go next.
                    latchedTargetNext = branch_target_i;
                    squashNext        = 1'b1;
                    ifIdInstNext      = '0;
                    ifIdValidNext     = 1'b0;
                end else if (!hold_i) begin
                    ifIdInstNext  = '0;
                    ifIdValidNext = 1'b0;
                end
            end

            HELD: begin
                if (flush_i) begin
                    pcNext        = branch_target_i;
                    ifIdInstNext  = '0;
                    ifIdValidNext = 1'b0;
                    stateNext     = FETCH;
                end else if (!hold_i) begin
                    ifIdPcNext    = skidPc;
                    ifIdInstNext  = skidInst;
                    ifIdValidNext = 1'b1;
                    stateNext     = FETCH;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            ifIdPc        <= '0;
            ifIdInst      <= '0;
            ifIdValid     <= 1'b0;
            skidInst      <= '0;
            skidPc        <= '0;
            squash        <= 1'b0;
            latchedTarget <= '0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            ifIdPc        <= ifIdPcNext;
            ifIdInst      <= ifIdInstNext;
            ifIdValid     <= ifIdValidNext;
            skidInst      <= skidInstNext;
            skidPc        <= skidPcNext;
            squash        <= squashNext;
            latchedTarget <= latchedTargetNext;
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubbleCnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubbleCnt <= '0;
        end else if (state != IDLE && !ifIdValid && bubbleCnt != 32'hFFFF_FFFF) begin
            bubbleCnt <= bubbleCnt + 32'd1;
        end
    end

    assign fetch_bubble_cnt_o = bubbleCnt;
`endif

    assign imem_req_o    = imemReq;
    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign if_id_pc_o    = ifIdPc;
    assign if_id_inst_o  = ifIdInst;
    assign if_id_valid_o = ifIdValid;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage with PC register and IF/ID pipeline register for the 5-stage MIPS core. It issues requests to instruction memory over a req/ack handshake and latches {PC+4, instruction} into IF/ID. It honours the hold request from the load-use hazard detection unit and the branch flush from ID. It buffers an instruction that returns during a hold, so no fetch is lost or duplicated.

Parameters:
ADDR_W, 32, PC / instruction address width
INST_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
clk_i  input  1  core clock, all state on rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  begin fetching; sampled only in IDLE
hold_i  input  1  stall from hazard detection unit; 1 = hold PC and IF/ID
flush_i  input  1  branch taken in ID; 1 = squash IF/ID and redirect PC
branch_target_i  input  ADDR_W  redirect address, valid with flush_i
imem_req_o  output  1  instruction memory request
imem_addr_o  output  ADDR_W  request address, equals PC
imem_ack_i  input  1  memory response valid; same cycle as req or any later cycle
imem_data_i  input  INST_W  instruction, valid with imem_ack_i
pc_o  output  ADDR_W  current PC register
if_id_pc_o  output  ADDR_W  IF/ID latched PC+4
if_id_inst_o  output  INST_W  IF/ID latched instruction; 0 (nop) when bubble
if_id_valid_o  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_i=1): state IDLE, pc=RESET_PC, imem_req_o=0, if_id_pc_o=0, if_id_inst_o=0, if_id_valid_o=0, skid buffer empty, squash flag=0, latched target=0.
- imem_addr_o = pc combinationally. imem_req_o=1 only in FETCH. The address is held stable until ack.
- PC increment is pc+4 modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Priority per cycle: flush_i > hold_i > normal advance.
- Bubble = if_id_inst_o=0, if_id_valid_o=0; if_id_pc_o unchanged.
- States:
  - IDLE: no request. start_i=1 -> FETCH next cycle. Any ack in IDLE is ignored.
  - FETCH: request pending.
    - ack and squash flag=1: discard data; pc<=latched target; clear squash; IF/ID bubble unless hold_i.
    - ack and flush_i: discard data; pc<=branch_target_i; IF/ID bubble.
    - ack and hold_i: skid<=imem_data_i, skid_pc<=pc+4; pc<=pc+4; IF/ID unchanged -> HELD.
    - ack, no flush or hold: IF/ID<={pc+4, imem_data_i, valid=1}; pc<=pc+4; stay FETCH with the next request in the next cycle.
    - no ack and flush_i: latched target<=branch_target_i; squash<=1; IF/ID bubble. The in-flight request completes on the old address and is discarded.
    - no ack and hold_i: IF/ID unchanged.
    - no ack otherwise: IF/ID bubble.
  - HELD: imem_req_o=0; IF/ID unchanged while hold_i=1.
    - flush_i: drop skid; pc<=branch_target_i; IF/ID bubble -> FETCH.
    - hold_i=0: IF/ID<={skid_pc, skid, valid=1} -> FETCH.
- Throughput: 1 instruction/cycle with zero-latency ack. Each instruction enters IF/ID exactly once.
- Reset mid-transaction: the outstanding request is abandoned. The first request after restart is to RESET_PC.
- start_i outside IDLE: ignored.

Optional Feature:
FETCH_BUBBLE_CNT_EN: adds output fetch_bubble_cnt_o (32 bits).
- It counts cycles outside IDLE in which if_id_valid_o=0.
- It saturates at 32'hFFFF_FFFF and resets to 0.
- Without the macro, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, start_i=1, ack every cycle with data 0x20080005, 0x20090003: imem_addr_o 0x0, 0x4, 0x8. IF/ID shows (pc 0x4, 0x20080005, valid) then (0x8, 0x20090003, valid).
- hold_i=1 for 2 cycles while in steady fetch with ack: IF/ID frozen. One fetched instruction sits in skid with no req during HELD. After release, IF/ID gets the skid value with no duplicate and no skipped address.
- flush_i=1, branch_target_i=0x40 in the same cycle as an ack of 0x10: data discarded, IF/ID bubble (inst 0, valid 0), next imem_addr_o=0x40.
- Ack delayed 3 cycles, flush_i pulsed in cycle 1 with target 0x80: bubble inserted, late ack discarded, next request addr 0x80.
- RESET_PC=32'hFFFF_FFFC, single fetch: next imem_addr_o=0x0. With FETCH_BUBBLE_CNT_EN and ack withheld 5 cycles after start, fetch_bubble_cnt_o=5.
- rst_i asserted mid-wait (req=1, no ack): outputs return to reset values immediately. An ack arriving in IDLE is ignored, and the first request after start_i is to RESET_PC.
